// File: rtl/ahb_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_apb_pkg
// Description : Shared types and constants for the AHB-Lite to APB3 bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_apb_pkg;

   // Bridge sequencing states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      ACCESS = 3'd2,
      DONE   = 3'd3,
      ERR1   = 3'd4,
      ERR2   = 3'd5
   } state_e;

   // AHB HTRANS encodings
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // Only word transfers are supported
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // A transfer is legal when it is a word access on a word-aligned address
   function automatic logic is_legal(input logic [2:0] hsize, input logic [1:0] addr_lo);
      return (hsize == HSIZE_WORD) && (addr_lo == 2'b00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ahbl2apb_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : ahbl2apb_bridge_if
// Description : AHB-Lite slave side and APB3 master side signals of the bridge.
//               'slave' is the bridge view, 'master' is the surrounding system.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahbl2apb_bridge_if #(
   parameter int PADDR_W = 32
);
   // AHB-Lite side
   logic               HSEL;
   logic [31:0]        HADDR;
   logic [1:0]         HTRANS;
   logic               HWRITE;
   logic [2:0]         HSIZE;
   logic               HREADY;
   logic [31:0]        HWDATA;
   logic [31:0]        HRDATA;
   logic               HREADYOUT;
   logic               HRESP;
   // APB3 side
   logic               PSEL;
   logic               PENABLE;
   logic [PADDR_W-1:0] PADDR;
   logic               PWRITE;
   logic [31:0]        PWDATA;
   logic [31:0]        PRDATA;
   logic               PREADY;
   logic               PSLVERR;

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
      input  PRDATA, PREADY, PSLVERR,
      output HRDATA, HREADYOUT, HRESP,
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA
   );

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
      output PRDATA, PREADY, PSLVERR,
      input  HRDATA, HREADYOUT, HRESP,
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA
   );

endinterface
`default_nettype wire

// File: rtl/ahbl2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ahbl2apb_bridge
// Description : AHB-Lite slave to APB3 master bridge. One word transfer at a
//               time, APB wait states stretch the AHB data phase, PSLVERR and
//               a PREADY timeout both produce a two-cycle AHB ERROR response.
// Revision    : 1.0 - initial release
// ============================================================================
module ahbl2apb_bridge
   import ahb_apb_pkg::*;
#(
   parameter int PADDR_W = 32,
   parameter int TIMEOUT = 255
) (
   input  wire logic          PCLK,
   input  wire logic          PRESETn,
   ahbl2apb_bridge_if.slave   bus
);

   // A zero TIMEOUT still needs a legal one-bit counter declaration
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   state_e             state_q, state_d;
   logic [PADDR_W-1:0] haddr_q, haddr_d;
   logic               hwrite_q, hwrite_d;
   logic [31:0]        hrdata_q, hrdata_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               accept;
   logic               legal;
   logic               psel;
   logic               penable;
   logic               hreadyout;
   logic               hresp;

   // Address-phase qualification: only NONSEQ/SEQ transfers with HREADY high
   always_comb begin
      accept = 1'b0;
      if (bus.HSEL && bus.HREADY &&
          ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ))) begin
         accept = 1'b1;
      end
      legal = is_legal(bus.HSIZE, bus.HADDR[1:0]);
   end

   // Next-state, capture registers and Moore bus outputs
   always_comb begin
      state_d   = state_q;
      haddr_d   = haddr_q;
      hwrite_d  = hwrite_q;
      hrdata_d  = hrdata_q;
      cnt_d     = cnt_q;
      psel      = 1'b0;
      penable   = 1'b0;
      hreadyout = 1'b1;
      hresp     = HRESP_OKAY;

      case (state_q)
         IDLE, DONE, ERR2: begin
            if (state_q == ERR2) begin
               hresp = HRESP_ERROR;
            end
            state_d = IDLE;
            if (accept) begin
               haddr_d  = bus.HADDR[PADDR_W-1:0];
               hwrite_d = bus.HWRITE;
               if (legal) begin
                  // Counter starts fresh for every APB access
                  cnt_d   = '0;
                  state_d = SETUP;
               end else begin
                  state_d = ERR1;
               end
            end
         end

         SETUP: begin
            psel      = 1'b1;
            hreadyout = 1'b0;
            state_d   = ACCESS;
         end

         ACCESS: begin
            psel      = 1'b1;
            penable   = 1'b1;
            hreadyout = 1'b0;
            if (bus.PREADY) begin
               if (bus.PSLVERR) begin
                  state_d = ERR1;
               end else begin
                  if (!hwrite_q) begin
                     hrdata_d = bus.PRDATA;
                  end
                  state_d = DONE;
               end
            end else if (TIMEOUT != 0) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = ERR1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         ERR1: begin
            hreadyout = 1'b0;
            hresp     = HRESP_ERROR;
            state_d   = ERR2;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and capture registers, asynchronously cleared
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q  <= IDLE;
         haddr_q  <= '0;
         hwrite_q <= 1'b0;
         hrdata_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         haddr_q  <= haddr_d;
         hwrite_q <= hwrite_d;
         hrdata_q <= hrdata_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.PSEL      = psel;
   assign bus.PENABLE   = penable;
   assign bus.PADDR     = haddr_q;
   assign bus.PWRITE    = hwrite_q;
   // Master holds HWDATA stable while the data phase is stretched
   assign bus.PWDATA    = bus.HWDATA;
   assign bus.HRDATA    = hrdata_q;
   assign bus.HREADYOUT = hreadyout;
   assign bus.HRESP     = hresp;

endmodule
`default_nettype wire

// File: tb/tb_ahbl2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahbl2apb_bridge
// Description : Directed self-checking bench for ahbl2apb_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahbl2apb_bridge;

   logic PCLK;
   logic PRESETn;
   int   vectors;
   int   miscompares;

   ahbl2apb_bridge_if #(.PADDR_W(32)) bus ();

   ahbl2apb_bridge #(
      .PADDR_W (32),
      .TIMEOUT (4)
   ) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .bus     (bus.slave)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive an AHB address phase
   task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz);
      bus.HSEL   = 1'b1;
      bus.HTRANS = 2'b10;
      bus.HADDR  = a;
      bus.HWRITE = wr;
      bus.HSIZE  = sz;
   endtask

   task automatic addr_idle();
      bus.HSEL   = 1'b0;
      bus.HTRANS = 2'b00;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      PRESETn     = 1'b0;
      bus.HSEL    = 1'b0;
      bus.HADDR   = 32'h0;
      bus.HTRANS  = 2'b00;
      bus.HWRITE  = 1'b0;
      bus.HSIZE   = 3'b010;
      bus.HREADY  = 1'b1;
      bus.HWDATA  = 32'h0;
      bus.PRDATA  = 32'h0;
      bus.PREADY  = 1'b1;
      bus.PSLVERR = 1'b0;

      // Reset values
      #12;
      chk("rst_psel",   {31'd0, bus.PSEL},      32'd0);
      chk("rst_pen",    {31'd0, bus.PENABLE},   32'd0);
      chk("rst_paddr",  bus.PADDR,              32'd0);
      chk("rst_pwrite", {31'd0, bus.PWRITE},    32'd0);
      chk("rst_hrdata", bus.HRDATA,             32'd0);
      chk("rst_hrdy",   {31'd0, bus.HREADYOUT}, 32'd1);
      chk("rst_hresp",  {31'd0, bus.HRESP},     32'd0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      tick();

      // BUSY transfer is ignored
      bus.HSEL = 1'b1; bus.HTRANS = 2'b01;
      tick();
      addr_idle();
      chk("busy_psel", {31'd0, bus.PSEL},      32'd0);
      chk("busy_hrdy", {31'd0, bus.HREADYOUT}, 32'd1);

      // Zero-wait write 0x7 to 0x100
      addr_phase(32'h100, 1'b1, 3'b010);
      chk("w1_A_psel", {31'd0, bus.PSEL}, 32'd0);
      tick();
      addr_idle();
      bus.HWDATA = 32'h7;
      chk("w1_setup_psel", {31'd0, bus.PSEL},      32'd1);
      chk("w1_setup_pen",  {31'd0, bus.PENABLE},   32'd0);
      chk("w1_paddr",      bus.PADDR,              32'h100);
      chk("w1_pwrite",     {31'd0, bus.PWRITE},    32'd1);
      chk("w1_pwdata",     bus.PWDATA,             32'h7);
      chk("w1_setup_hrdy", {31'd0, bus.HREADYOUT}, 32'd0);
      tick();
      chk("w1_acc_psel", {31'd0, bus.PSEL},      32'd1);
      chk("w1_acc_pen",  {31'd0, bus.PENABLE},   32'd1);
      chk("w1_acc_hrdy", {31'd0, bus.HREADYOUT}, 32'd0);
      chk("w1_acc_paddr", bus.PADDR,             32'h100);
      tick();
      chk("w1_done_hrdy",  {31'd0, bus.HREADYOUT}, 32'd1);
      chk("w1_done_hresp", {31'd0, bus.HRESP},     32'd0);
      chk("w1_done_psel",  {31'd0, bus.PSEL},      32'd0);
      chk("w1_hrdata",     bus.HRDATA,             32'd0);
      tick();

      // Read 0x04 with three stalled ACCESS cycles
      addr_phase(32'h4, 1'b0, 3'b010);
      tick();
      addr_idle();
      bus.PREADY = 1'b0;
      chk("r1_setup_psel", {31'd0, bus.PSEL}, 32'd1);
      tick();
      chk("r1_acc1_pen",  {31'd0, bus.PENABLE},   32'd1);
      chk("r1_acc1_hrdy", {31'd0, bus.HREADYOUT}, 32'd0);
      tick();
      chk("r1_acc2_hrdy", {31'd0, bus.HREADYOUT}, 32'd0);
      tick();
      chk("r1_acc3_hrdy", {31'd0, bus.HREADYOUT}, 32'd0);
      tick();
      bus.PREADY = 1'b1;
      bus.PRDATA = 32'h1234_5678;
      chk("r1_acc4_pen",    {31'd0, bus.PENABLE},   32'd1);
      chk("r1_acc4_hrdy",   {31'd0, bus.HREADYOUT}, 32'd0);
      chk("r1_acc4_hrdata", bus.HRDATA,             32'd0);
      tick();
      chk("r1_done_hrdy",   {31'd0, bus.HREADYOUT}, 32'd1);
      chk("r1_done_hresp",  {31'd0, bus.HRESP},     32'd0);
      chk("r1_hrdata",      bus.HRDATA,             32'h1234_5678);
      tick();

      // Back-to-back write 0x08 then read 0x200 presented in DONE
      addr_phase(32'h8, 1'b1, 3'b010);
      tick();
      addr_idle();
      bus.HWDATA = 32'hDEAD_BEEF;
      chk("bb_w_paddr", bus.PADDR, 32'h8);
      tick();
      chk("bb_w_pen", {31'd0, bus.PENABLE}, 32'd1);
      tick();
      addr_phase(32'h200, 1'b0, 3'b010);
      chk("bb_done_psel", {31'd0, bus.PSEL},      32'd0);
      chk("bb_done_hrdy", {31'd0, bus.HREADYOUT}, 32'd1);
      chk("bb_hrdata_kept", bus.HRDATA,           32'h1234_5678);
      tick();
      addr_idle();
      bus.PRDATA = 32'hCAFE_F00D;
      chk("bb_r_psel",   {31'd0, bus.PSEL},    32'd1);
      chk("bb_r_pen",    {31'd0, bus.PENABLE}, 32'd0);
      chk("bb_r_paddr",  bus.PADDR,            32'h200);
      chk("bb_r_pwrite", {31'd0, bus.PWRITE},  32'd0);
      tick();
      tick();
      chk("bb_r_hrdata", bus.HRDATA, 32'hCAFE_F00D);
      tick();

      // PSLVERR on write to 0x0C
      addr_phase(32'hC, 1'b1, 3'b010);
      tick();
      addr_idle();
      tick();
      bus.PSLVERR = 1'b1;
      chk("se_acc_pen", {31'd0, bus.PENABLE}, 32'd1);
      tick();
      bus.PSLVERR = 1'b0;
      chk("se_err1_hrdy",  {31'd0, bus.HREADYOUT}, 32'd0);
      chk("se_err1_hresp", {31'd0, bus.HRESP},     32'd1);
      chk("se_err1_psel",  {31'd0, bus.PSEL},      32'd0);
      tick();
      chk("se_err2_hrdy",  {31'd0, bus.HREADYOUT}, 32'd1);
      chk("se_err2_hresp", {31'd0, bus.HRESP},     32'd1);
      tick();
      chk("se_idle_hresp", {31'd0, bus.HRESP},     32'd0);
      chk("se_idle_hrdy",  {31'd0, bus.HREADYOUT}, 32'd1);

      // Illegal size: halfword
      addr_phase(32'h10, 1'b1, 3'b001);
      tick();
      addr_idle();
      chk("sz_err1_psel",  {31'd0, bus.PSEL},      32'd0);
      chk("sz_err1_hrdy",  {31'd0, bus.HREADYOUT}, 32'd0);
      chk("sz_err1_hresp", {31'd0, bus.HRESP},     32'd1);
      tick();
      chk("sz_err2_psel",  {31'd0, bus.PSEL},      32'd0);
      chk("sz_err2_hresp", {31'd0, bus.HRESP},     32'd1);
      tick();

      // Misaligned word, then a legal read presented in ERR2
      addr_phase(32'h102, 1'b0, 3'b010);
      tick();
      addr_idle();
      chk("al_err1_psel",  {31'd0, bus.PSEL},  32'd0);
      chk("al_err1_hresp", {31'd0, bus.HRESP}, 32'd1);
      tick();
      addr_phase(32'h40, 1'b0, 3'b010);
      chk("al_err2_hrdy",  {31'd0, bus.HREADYOUT}, 32'd1);
      chk("al_err2_psel",  {31'd0, bus.PSEL},      32'd0);
      tick();
      addr_idle();
      bus.PRDATA = 32'h0000_0040;
      chk("e2acc_psel",  {31'd0, bus.PSEL}, 32'd1);
      chk("e2acc_paddr", bus.PADDR,         32'h40);
      tick();
      tick();
      chk("e2acc_hrdata", bus.HRDATA, 32'h0000_0040);
      tick();

      // Timeout after 4 stalled ACCESS cycles
      addr_phase(32'h20, 1'b0, 3'b010);
      tick();
      addr_idle();
      bus.PREADY = 1'b0;
      bus.PRDATA = 32'hFFFF_FFFF;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("to_acc%0d_psel", i), {31'd0, bus.PSEL},    32'd1);
         chk($sformatf("to_acc%0d_pen", i),  {31'd0, bus.PENABLE}, 32'd1);
      end
      tick();
      chk("to_err1_psel",  {31'd0, bus.PSEL},      32'd0);
      chk("to_err1_pen",   {31'd0, bus.PENABLE},   32'd0);
      chk("to_err1_hresp", {31'd0, bus.HRESP},     32'd1);
      chk("to_err1_hrdy",  {31'd0, bus.HREADYOUT}, 32'd0);
      chk("to_hrdata",     bus.HRDATA,             32'h0000_0040);
      tick();
      chk("to_err2_hrdy",  {31'd0, bus.HREADYOUT}, 32'd1);
      tick();
      bus.PREADY = 1'b1;

      // Reset during ACCESS, then a normal read of 0x00
      addr_phase(32'h30, 1'b1, 3'b010);
      tick();
      addr_idle();
      bus.PREADY = 1'b0;
      tick();
      chk("rs_acc_pen", {31'd0, bus.PENABLE}, 32'd1);
      #2;
      PRESETn = 1'b0;
      #1;
      chk("rs_psel",   {31'd0, bus.PSEL},      32'd0);
      chk("rs_pen",    {31'd0, bus.PENABLE},   32'd0);
      chk("rs_hrdy",   {31'd0, bus.HREADYOUT}, 32'd1);
      chk("rs_paddr",  bus.PADDR,              32'd0);
      chk("rs_hrdata", bus.HRDATA,             32'd0);
      @(negedge PCLK);
      PRESETn    = 1'b1;
      bus.PREADY = 1'b1;
      bus.PRDATA = 32'hA5A5_0001;
      tick();
      addr_phase(32'h0, 1'b0, 3'b010);
      tick();
      addr_idle();
      chk("pr_psel",  {31'd0, bus.PSEL}, 32'd1);
      chk("pr_paddr", bus.PADDR,         32'd0);
      tick();
      chk("pr_pen", {31'd0, bus.PENABLE}, 32'd1);
      tick();
      chk("pr_hrdy",   {31'd0, bus.HREADYOUT}, 32'd1);
      chk("pr_hrdata", bus.HRDATA,             32'hA5A5_0001);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
